fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, which also caps requests in flight plus entries buffered; legal range 2..8.
REQ-003 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1: synchronous, active-high reset.
REQ-005 Port imem_req_valid, output, 1: fetch request valid.
REQ-006 Port imem_req_ready, input, 1: memory accepts the request.
REQ-007 Port imem_req_addr, output, 32: word-aligned fetch address.
REQ-008 Port imem_rsp_valid, input, 1: response valid; responses arrive in order, at least 1 cycle after acceptance.
REQ-009 Port imem_rsp_data, input, 32: instruction word.
REQ-010 Port redirect_valid, input, 1: branch/jump redirect from execute.
REQ-011 Port redirect_pc, input, 32: redirect target.
REQ-012 Port stall, input, 1: decode cannot accept this cycle.
REQ-013 Port inst_valid, output, 1: inst/inst_pc valid toward decode.
REQ-014 Port inst, output, 32: instruction toward the fetch-to-decode pipeline register.
REQ-015 Port inst_pc, output, 32: address of inst.

Function
REQ-016 FSM states: FETCH (normal operation) and DRAIN (discard stale responses).
REQ-017 In FETCH, imem_req_valid shall be 1 when outstanding + buffered < DEPTH and redirect_valid = 0; imem_req_addr = pc.
REQ-018 On imem_req_valid && imem_req_ready: pc <= pc + 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0); the request PC is queued in order.
REQ-019 On imem_rsp_valid in FETCH: {queued PC, imem_rsp_data} is pushed into the buffer and outstanding decrements.
REQ-020 inst_valid = buffer not empty; inst/inst_pc come from the head entry, combinationally from registers.
REQ-021 Pop when inst_valid && !stall; when stall = 1, inst/inst_pc hold stable.
REQ-022 Simultaneous push and pop with a full buffer is legal; count is unchanged.
REQ-023 On redirect_valid: flush the buffer and PC queue, pc <= {redirect_pc[31:2], 2'b00}, no pop, no request that cycle; redirect has priority over every other event.
REQ-024 A redirect with outstanding > 0 (after counting a same-cycle response) moves the FSM to DRAIN with drop_cnt = outstanding; otherwise the FSM stays in FETCH.
REQ-025 In DRAIN, imem_req_valid = 0 and inst_valid = 0; each response is discarded and decrements drop_cnt; the FSM returns to FETCH the cycle after drop_cnt reaches 0.
REQ-026 A redirect while in DRAIN updates pc and keeps the FSM in DRAIN.
REQ-027 imem_rsp_valid with outstanding = 0 is a protocol error; it is ignored, with a simulation-only assertion.

Reset
REQ-028 When RST = 1 at the clock edge: pc = RESET_PC, state = FETCH, buffer/queue/outstanding/drop_cnt = 0, inst_valid = 0, imem_req_valid = 0 that cycle, inst = 0, inst_pc = 0.
REQ-029 Reset during DRAIN or with requests in flight abandons them; the memory side is reset on the same RST.

Configuration
REQ-030 Macro FETCH_PERF_EN defined: adds output ports perf_fetched (32 bits, pops) and perf_stall_cycles (32 bits, cycles with inst_valid && stall); both zero on reset and wrap at 2^32.
REQ-031 Macro FETCH_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-032 Package fetch_pkg holds fetch_state_e {FETCH, DRAIN}, struct fetch_entry_t {pc[31:0], inst[31:0]}, and constant INST_BYTES = 4.
REQ-033 Sub-module fetch_fifo (parameterised depth, fetch_entry_t payload, push/pop/flush, full/empty) implements the buffer and is reused for the PC queue.

Verification
REQ-034 Reset, ready = 1, 1-cycle memory, stall = 0 -> requests at 0x0, 0x4, 0x8; inst_pc sequence 0x0, 0x4, 0x8 with no gaps after the first valid.
REQ-035 stall held 5 cycles with DEPTH = 2 -> at most 2 requests in flight plus buffered; inst stable; no request issued while the buffer is full.
REQ-036 Redirect to 0x103 with 2 requests outstanding -> FSM in DRAIN, both responses dropped, next request addr 0x100, first delivered inst_pc 0x100.
REQ-037 Redirect in the same cycle as a response and a pop -> the buffer is empty next cycle and the response is not delivered.
REQ-038 pc = 0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
REQ-039 Under FETCH_PERF_EN, 10 delivered instructions and 3 stalled cycles -> perf_fetched = 10, perf_stall_cycles = 3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries with flush; used for the
// instruction buffer and for the in-flight PC queue.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  fetch_entry_t  i_din,
    output fetch_entry_t  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rd];

    // A full FIFO still accepts a push when it pops in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= nxt(r_wr);
            end
            if (w_pop) begin
                r_rd <= nxt(r_rd);
            end
            unique case (1'b1)
                (w_push && !w_pop): r_cnt <= r_cnt + CW'(1);
                (w_pop && !w_push): r_cnt <= r_cnt - CW'(1);
                default:            r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with bounded in-flight requests, redirect and drain.
// Optional counters: define FETCH_PERF_EN for perf_fetched/perf_stall_cycles.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_n;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_n;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_drop_n;

    logic          w_req;
    logic          w_flush;
    logic          w_pcq_push;
    logic          w_pcq_pop;
    logic          w_buf_push;
    logic          w_buf_pop;
    logic          w_rsp_hit;
    logic          w_inst_valid;
    logic          w_pop_ok;
    logic          w_room;
    logic [CW:0]   w_inflight;
    logic [CW-1:0] w_left;
    logic [31:0]   w_redir_pc;

    fetch_entry_t  w_pcq_din;
    fetch_entry_t  w_pcq_head;
    fetch_entry_t  w_buf_din;
    fetch_entry_t  w_buf_head;
    logic          w_pcq_full;
    logic          w_pcq_empty;
    logic [CW-1:0] w_pcq_cnt;
    logic          w_buf_full;
    logic          w_buf_empty;
    logic [CW-1:0] w_buf_cnt;
    logic          w_unused;

    assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
    assign w_inst_valid = (r_state == FETCH) && !w_buf_empty;
    assign w_pop_ok     = w_inst_valid && !stall && !redirect_valid;
    assign w_rsp_hit    = (r_state == FETCH) && imem_rsp_valid && !w_pcq_empty;
    assign w_left       = w_pcq_cnt - CW'(w_rsp_hit);

    // A same-cycle pop frees a slot, so streaming runs without bubbles.
    assign w_inflight = {1'b0, w_pcq_cnt} + {1'b0, w_buf_cnt};
    assign w_room     = w_inflight < ((CW + 1)'(DEPTH) + {{CW{1'b0}}, w_pop_ok});

    assign w_pcq_push = w_req && imem_req_ready;
    assign w_pcq_din  = '{pc: r_pc, inst: 32'h0};
    assign w_buf_din  = '{pc: w_pcq_head.pc, inst: imem_rsp_data};

    always_comb begin
        w_state_n  = r_state;
        w_pc_n     = r_pc;
        w_drop_n   = r_drop_cnt;
        w_req      = 1'b0;
        w_flush    = 1'b0;
        w_pcq_pop  = 1'b0;
        w_buf_push = 1'b0;
        w_buf_pop  = 1'b0;
        unique case (r_state)
            FETCH: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    w_pc_n  = w_redir_pc;
                    if (w_left != '0) begin
                        w_state_n = DRAIN;
                        w_drop_n  = w_left;
                    end
                end else begin
                    w_req      = w_room && !RST;
                    w_pcq_pop  = w_rsp_hit;
                    w_buf_push = w_rsp_hit;
                    w_buf_pop  = w_pop_ok;
                    if (w_req && imem_req_ready) begin
                        w_pc_n = r_pc + INST_BYTES;
                    end
                end
            end
            DRAIN: begin
                if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                    w_drop_n = r_drop_cnt - CW'(1);
                end
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    w_pc_n  = w_redir_pc;
                end else if (w_drop_n == '0) begin
                    w_state_n = FETCH;
                end
            end
            default: begin
                w_state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_drop_cnt <= w_drop_n;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_pcq (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (w_flush),
        .i_push  (w_pcq_push),
        .i_pop   (w_pcq_pop),
        .i_din   (w_pcq_din),
        .o_head  (w_pcq_head),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty),
        .o_count (w_pcq_cnt)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_buf (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (w_flush),
        .i_push  (w_buf_push),
        .i_pop   (w_buf_pop),
        .i_din   (w_buf_din),
        .o_head  (w_buf_head),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_cnt)
    );

    assign imem_req_valid = w_req;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = w_inst_valid;
    assign inst           = w_inst_valid ? w_buf_head.inst : 32'h0;
    assign inst_pc        = w_inst_valid ? w_buf_head.pc : 32'h0;

    assign w_unused = ^{w_pcq_head.inst, w_pcq_full, w_buf_full, redirect_pc[1:0]};

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_buf_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_inst_valid && stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched      = r_perf_fetched;
    assign perf_stall_cycles = r_perf_stall;
`endif

`ifndef SYNTHESIS
    // A response with nothing in flight is a memory-side protocol error.
    a_rsp_expected: assert property (@(posedge CLK) disable iff (RST)
        imem_rsp_valid |-> ((r_state == FETCH) ? !w_pcq_empty : (r_drop_cnt != '0)));
`endif

endmodule
